// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix one row at a time,
// classifies each full scan, debounces press and release, and emits one
// decoded key code with a single-cycle enter strobe per physical press.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,  // cycles each row is driven, >= 4
    parameter int DEBOUNCE = 8      // matching scans to accept press/release, 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] digit,
    output logic       enter
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       DEB_N    = 8'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, CHECK, PRESSED} state_t;

    // Key code at a (row, col) matrix position.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
            4'hC: key_code = 4'hE;  4'hD: key_code = 4'h0;
            4'hE: key_code = 4'hF;  default: key_code = 4'hD;
        endcase
    endfunction

    logic [3:0]       col_s1_q, col_s2_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [1:0]       row_idx_q;
    logic [1:0]       det_cnt_q, det_cnt_d;   // detections so far, saturates at 2
    logic [3:0]       det_code_q, det_code_d;
    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       digit_q, digit_d;
    logic             enter_q, enter_d;

    logic       sample_en, scan_tick;
    logic [2:0] samp_cnt, total;
    logic [1:0] samp_col, scan_cnt;
    logic [3:0] scan_code;

    assign sample_en = (div_cnt_q == DIV_LAST);
    assign scan_tick = sample_en && (row_idx_q == 2'd3);

    // Two-stage synchronizer for the asynchronous column inputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
        end else begin
            col_s1_q <= col_n;
            col_s2_q <= col_s1_q;
        end
    end

    // Row slot divider and row rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            row_idx_q <= '0;
        end else if (sample_en) begin
            div_cnt_q <= '0;
            row_idx_q <= row_idx_q + 2'd1;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    // Count low columns in the current sample and merge with the scan so far.
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        samp_cnt = '0;
        samp_col = '0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_s2_q[c]) begin
                samp_cnt = samp_cnt + 3'd1;
                samp_col = c[1:0];
            end
        end
        total     = {1'b0, det_cnt_q} + (sample_en ? samp_cnt : 3'd0);
        scan_cnt  = (total >= 3'd2) ? 2'd2 : total[1:0];
        scan_code = (det_cnt_q == 2'd1) ? det_code_q : key_code(row_idx_q, samp_col);
        det_cnt_d  = det_cnt_q;
        det_code_d = det_code_q;
        if (scan_tick) begin
            det_cnt_d = '0;
        end else if (sample_en) begin
            det_cnt_d  = scan_cnt;
            det_code_d = scan_code;
        end
    end

    // Debounce FSM: next state, counter, candidate and accept outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        digit_d = digit_q;
        enter_d = 1'b0;
        if (scan_tick) begin
            case (state_q)
                IDLE: begin
                    if (scan_cnt == 2'd1) begin
                        cand_d = scan_code;
                        if (DEBOUNCE == 1) begin
                            digit_d = scan_code;
                            enter_d = 1'b1;
                            cnt_d   = '0;
                            state_d = PRESSED;
                        end else begin
                            cnt_d   = 8'd1;
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (scan_cnt == 2'd1 && scan_code == cand_q) begin
                        if (cnt_q + 8'd1 == DEB_N) begin
                            digit_d = cand_q;
                            enter_d = 1'b1;
                            cnt_d   = '0;
                            state_d = PRESSED;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin  // PRESSED: any detection, including MULTI, restarts release
                    if (scan_cnt == 2'd0) begin
                        if (cnt_q + 8'd1 == DEB_N) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            endcase
        end
    end

    // Detection accumulator and debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            det_cnt_q  <= '0;
            det_code_q <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= '0;
            digit_q    <= '0;
            enter_q    <= 1'b0;
        end else begin
            det_cnt_q  <= det_cnt_d;
            det_code_q <= det_code_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            digit_q    <= digit_d;
            enter_q    <= enter_d;
        end
    end

    assign row_n = ~(4'b0001 << row_idx_q);
    assign digit = digit_q;
    assign enter = enter_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Upstream front end for the 4-digit combination lock: scans a 4x4 active-low matrix keypad, debounces presses and releases, and delivers one decoded key per physical press. It supplies the lock FSM's `digit` bus and its `enter` strobe, so each press advances the lock by exactly one step.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is driven. Legal range is 4 or more.
- `DEBOUNCE`, default 8: consecutive identical full scans required to accept a press and to accept a release. Legal range is 1 to 255.

- `clk`  in  1: system clock. Single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `col_n`  in  4: keypad columns, active-low, externally pulled up, asynchronous.
- `row_n`  out  4: keypad row drive, active-low, one row low at a time.
- `digit`  out  4: last accepted key code, held until the next accepted key.
- `enter`  out  1: one-cycle strobe; `digit` is valid in the same cycle.

## Operation
- **Synchronizer:** `col_n` passes through a 2-FF synchronizer; both stages reset to 4'b1111.
- **Scan counter:**
  - `div_cnt` counts 0..SCAN_DIV-1; `row_idx` counts 0..3 and advances when `div_cnt` wraps.
  - `row_n` = ~(1 << `row_idx`).
- **Sampling:**
  - Synchronized columns are sampled on the last cycle of each row slot (`div_cnt` = SCAN_DIV-1).
  - Each low column in a sample counts as one detected key at (`row_idx`, col).
- **Scan evaluation:** `scan_tick` = (`row_idx` = 3 and `div_cnt` = SCAN_DIV-1). On `scan_tick`, the scan result, including the row-3 sample taken in that same cycle, is classified as:
  - NONE: 0 detections.
  - SINGLE(code): exactly 1 detection.
  - MULTI: 2 or more detections.
  - The detection accumulator then clears.
- **Key map** (row: col0..col3):
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: E (*), 0, F (#), D
- **Debounce FSM** (updates only on `scan_tick`):
  - IDLE: on SINGLE(k), latch candidate=k, set cnt=1, go CHECK. If DEBOUNCE=1, accept immediately instead and go PRESSED. On NONE or MULTI, stay.
  - CHECK: on SINGLE(candidate), cnt++. When cnt reaches DEBOUNCE, accept and go PRESSED. On any other result, go IDLE without accepting.
  - PRESSED: on NONE, cnt++; otherwise cnt=0. When cnt reaches DEBOUNCE, clear cnt and go IDLE.
  - Entry into PRESSED clears cnt.
- **Accept:** at that clock edge `digit` <= candidate and `enter` <= 1. On the next edge `enter` <= 0.
- **Press counting:** a held key produces exactly one strobe. MULTI never produces a strobe. A MULTI seen in PRESSED blocks release.

## Timing
- **Reset values:**
  - `row_n` = 4'b1110, `digit` = 4'h0, `enter` = 0.
  - FSM in IDLE; `div_cnt`, `row_idx`, cnt all 0.
- **Scan period:** 4*SCAN_DIV cycles.
- **Column settle:** column input must settle within SCAN_DIV-3 cycles of a row change, which covers the 2-cycle synchronizer.
- **Press latency:** from a column becoming stable before a scan begins, `enter` rises 1 cycle after the DEBOUNCE-th matching `scan_tick`.
- **Release:** re-arm needs DEBOUNCE consecutive NONE scans. A press during that window restarts the count and produces no strobe.
- **Enter spacing:** `enter` is never high in two consecutive cycles. Minimum spacing between strobes is (2*DEBOUNCE)*4*SCAN_DIV cycles.
- **Reset mid-operation:** a reset in any state aborts it with no strobe. All outputs take their reset values at the next edge. A key already held at reset must be re-debounced from IDLE.

## Test plan
Unless noted, benches use SCAN_DIV=4 and DEBOUNCE=3, giving a 16-cycle scan.
1. **Reset and row rotation:** assert `reset` for 3 cycles -> `digit`=0 and `enter`=0. After release, `row_n` steps 1110, 1101, 1011, 0111 every 4 cycles and wraps.
2. **Single press:**
   - Hold row2/col2 for 10 scans, then release for 5 scans -> exactly one `enter` pulse with `digit`=9.
   - Then hold row2/col0 -> one pulse with `digit`=7.
3. **Bounce and short press:**
   - Key 5 toggling every 8 cycles for 2 scans, then stable -> a single pulse (`digit`=5) after 3 stable scans.
   - A 2-scan press -> no pulse.
4. **Multi-key:** hold keys 1 and 2 together for 6 scans -> no pulse. Release key 2 only -> one pulse with `digit`=1 after 3 scans.
5. **Held and release-debounce:** hold key D for 20 scans -> one pulse. Release for 2 scans, re-press D for 6 scans -> no new pulse.
6. **Reset and integration:**
   - Reset while in CHECK with cnt=2 -> no pulse.
   - Connect `digit`/`enter` to the lock and press 9, 9, 7, 9 -> lock `unlocked`=1.
